// File: rtl/ucaspian_synapse.sv
// Synapse fetch stage: walks an inclusive synapse index range and emits (neuron, weight) events.
// Optional build macro UCASPIAN_SYN_SKIP_ZERO_EN drops zero-weight entries before buffering.
module ucaspian_synapse #(
    parameter int ADDR_W    = 12,
    parameter int WEIGHT_W  = 8,
    parameter int NEURON_W  = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       clear_config,
    output logic                       clear_done,
    input  logic [ADDR_W-1:0]          config_addr,
    input  logic [7:0]                 config_value,
    input  logic [2:0]                 config_byte,
    input  logic                       config_enable,
    input  logic                       next_step,
    output logic                       step_done,
    input  logic [ADDR_W-1:0]          syn_start,
    input  logic [ADDR_W-1:0]          syn_end,
    input  logic                       syn_vld,
    output logic                       syn_rdy,
    output logic [NEURON_W-1:0]        dend_addr,
    output logic signed [WEIGHT_W-1:0] dend_weight,
    output logic                       dend_vld,
    input  logic                       dend_rdy
);
    localparam int ENTRY_W = WEIGHT_W + NEURON_W;
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(OUT_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [ENTRY_W-1:0]  syn_ram [0:(1<<ADDR_W)-1];
    logic [WEIGHT_W-1:0] stage_hi;
    logic [0:0]          state;
    logic [ADDR_W-1:0]   cur_p0;
    logic [ADDR_W-1:0]   last_p0;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ENTRY_W-1:0]  ram_q_p0;
    logic                rd_en_p0;
    logic                push_vld_p0;
    logic [ENTRY_W-1:0]  buf_mem_p1 [0:OUT_DEPTH-1];
    logic [ENTRY_W-1:0]  head_p1;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    buf_cnt;
    logic                xfer;
    logic                pop;
    logic                clearing;
    logic                cfg_wr;

    assign syn_rdy  = (state == IDLE) && enable && !clear_config && reset_n;
    assign xfer     = syn_vld && syn_rdy;
    assign clearing = clear_config && !clear_done;
    assign cfg_wr   = config_enable && !clear_config && (config_byte == 3'd3);

    // p0: read issue; the entry lands in the output buffer at the same edge
    assign rd_en_p0 = (state == RUN) && !clear_config && (buf_cnt < DEPTH_C);
    assign ram_q_p0 = syn_ram[cur_p0];
`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
    assign push_vld_p0 = rd_en_p0 && (ram_q_p0[ENTRY_W-1 -: WEIGHT_W] != '0);
`else
    assign push_vld_p0 = rd_en_p0;
`endif

    // p1: buffer head drives the dendrite port, zeroed while empty
    assign head_p1     = buf_mem_p1[rd_ptr];
    assign dend_vld    = (buf_cnt != '0);
    assign pop         = dend_vld && dend_rdy;
    assign dend_addr   = dend_vld ? head_p1[NEURON_W-1:0] : '0;
    assign dend_weight = dend_vld ? $signed(head_p1[ENTRY_W-1 -: WEIGHT_W]) : '0;

    always_ff @(posedge clk) begin
        if (clearing) begin
            syn_ram[clr_addr] <= '0;
        end else if (cfg_wr) begin
            syn_ram[config_addr] <= {stage_hi, config_value};
        end
    end

    always_ff @(posedge clk) begin
        if (config_enable && !clear_config) begin
            if (config_byte == 3'd1) begin
                stage_hi <= '0;
            end else if (config_byte == 3'd2) begin
                stage_hi <= config_value;
            end
        end
        if (xfer) begin
            cur_p0  <= syn_start;
            last_p0 <= syn_end;
        end else if (rd_en_p0) begin
            cur_p0 <= cur_p0 + ADDR_W'(1);
        end
        if (push_vld_p0) begin
            buf_mem_p1[wr_ptr] <= ram_q_p0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_cnt    <= '0;
            clr_addr   <= '0;
            clear_done <= 1'b0;
            step_done  <= 1'b0;
        end else begin
            // clear aborts any burst and discards buffered events
            if (clear_config) begin
                state   <= IDLE;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                buf_cnt <= '0;
            end else begin
                if (state == IDLE) begin
                    if (xfer) state <= RUN;
                end else if (rd_en_p0 && (cur_p0 == last_p0)) begin
                    state <= IDLE;
                end
                if (push_vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)         rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_vld_p0 && !pop) begin
                    buf_cnt <= buf_cnt + CNT_W'(1);
                end else if (!push_vld_p0 && pop) begin
                    buf_cnt <= buf_cnt - CNT_W'(1);
                end
            end

            if (clear_config) begin
                if (!clear_done) begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == LAST_ADDR) clear_done <= 1'b1;
                end
            end else begin
                clr_addr   <= '0;
                clear_done <= 1'b0;
            end

            step_done <= (state == IDLE) && (buf_cnt == '0) && !syn_vld
                         && !clear_config && !next_step;
        end
    end
endmodule
